// File: rtl/axis_pkg.sv
// Shared AXI-Stream beat type and sizing helpers for the elastic pipeline.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 64;
    localparam int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic [AXIS_KEEP_WIDTH-1:0] tkeep;
        logic                       tlast;
    } axis_beat_t;

    // Counter width able to hold 0..2*stages buffered beats.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/axis_skid_stage.sv
// One registered main/skid pair: 1 cycle latency, holds up to 2 beats.
// Upstream ready is a register (NOT skid valid), so m_rdy never reaches s_rdy combinationally.
module axis_skid_stage #(
    parameter int WIDTH = 73
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] s_dat,
    input  logic             s_vld,
    output logic             s_rdy,
    output logic [WIDTH-1:0] m_dat,
    output logic             m_vld,
    input  logic             m_rdy
);

    logic [WIDTH-1:0] main_dat, main_dat_n;
    logic [WIDTH-1:0] skid_dat, skid_dat_n;
    logic             main_vld, main_vld_n;
    logic             skid_vld, skid_vld_n;
    logic             rdy_q;
    logic             acc;

    assign acc   = s_vld & rdy_q;
    assign s_rdy = rdy_q;
    assign m_dat = main_dat;
    assign m_vld = main_vld;

    always_comb begin
        main_vld_n = main_vld;
        main_dat_n = main_dat;
        skid_vld_n = skid_vld;
        skid_dat_n = skid_dat;
        if (skid_vld) begin
            // A full stage refuses input; a drain refills main from skid.
            if (m_rdy) begin
                main_dat_n = skid_dat;
                skid_vld_n = 1'b0;
            end
        end else if (!main_vld || m_rdy) begin
            main_vld_n = acc;
            if (acc) begin
                main_dat_n = s_dat;
            end
        end else if (acc) begin
            skid_vld_n = 1'b1;
            skid_dat_n = s_dat;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
            rdy_q    <= 1'b0;
        end else begin
            main_vld <= main_vld_n;
            skid_vld <= skid_vld_n;
            main_dat <= main_dat_n;
            skid_dat <= skid_dat_n;
            rdy_q    <= !skid_vld_n;
        end
    end

endmodule

// File: rtl/axis_pipeline.sv
// Elastic AXI-Stream pipeline of STAGES skid stages: STAGES cycles latency, 1 beat/cycle, 2*STAGES beats of buffering.
// Optional AXIS_PIPELINE_OCC_EN adds occupancy_out, the count of buffered beats.
module axis_pipeline
    import axis_pkg::*;
#(
    parameter int STAGES     = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
`ifdef AXIS_PIPELINE_OCC_EN
    output logic [occ_width(STAGES)-1:0] occupancy_out,
`endif
    input  logic                  m_axis_tready
);

    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

    if (STAGES < 1) begin : g_bad_stages
        $error("axis_pipeline: STAGES must be >= 1");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("axis_pipeline: DATA_WIDTH must be a multiple of 8");
    end
    if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep
        $error("axis_pipeline: KEEP_WIDTH is derived from DATA_WIDTH");
    end

    // Index i is the link feeding stage i; index STAGES is the m-side port.
    logic [BEAT_W-1:0] dat [STAGES+1];
    logic              vld [STAGES+1];
    logic              rdy [STAGES+1];

    assign dat[0]        = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    assign vld[0]        = s_axis_tvalid;
    assign s_axis_tready = rdy[0];

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = dat[STAGES];
    assign m_axis_tvalid = vld[STAGES];
    assign rdy[STAGES]   = m_axis_tready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        axis_skid_stage #(
            .WIDTH (BEAT_W)
        ) u_stage (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .s_dat    (dat[i]),
            .s_vld    (vld[i]),
            .s_rdy    (rdy[i]),
            .m_dat    (dat[i+1]),
            .m_vld    (vld[i+1]),
            .m_rdy    (rdy[i+1])
        );
    end

`ifdef AXIS_PIPELINE_OCC_EN
    localparam int OCC_W = occ_width(STAGES);

    logic [OCC_W-1:0] occ;
    logic             s_xfer;
    logic             m_xfer;

    assign s_xfer        = s_axis_tvalid & s_axis_tready;
    assign m_xfer        = m_axis_tvalid & m_axis_tready;
    assign occupancy_out = occ;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            occ <= '0;
        end else begin
            case ({s_xfer, m_xfer})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end
`endif

endmodule
